// File: rtl/binary_value_prioritizer_p.sv
// Types and encodings shared by the prioritizer cell bank and its arbiter.
package binary_value_prioritizer_p;

  localparam logic [1:0] ARB_ENC_SEARCH  = 2'd0;
  localparam logic [1:0] ARB_ENC_LOCKED  = 2'd1;
  localparam logic [1:0] ARB_ENC_HANDOFF = 2'd2;

  typedef enum logic [1:0] {
    ST_SEARCH  = ARB_ENC_SEARCH,
    ST_LOCKED  = ARB_ENC_LOCKED,
    ST_HANDOFF = ARB_ENC_HANDOFF
  } arb_state_e;

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle carried by every block in the cell-bank subsystem.
package common_p;

  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;

endpackage

// File: rtl/binary_value_argmax.sv
// Combinational argmax over packed saturation counts; excluded cells never win,
// equal counts resolve to the lowest index.
module binary_value_argmax #(
  parameter int CELL_COUNT      = 4,
  parameter int COUNT_BIT_WIDTH = 8,
  parameter int INDEX_BIT_WIDTH = $clog2(CELL_COUNT)
) (
  input  logic [CELL_COUNT*COUNT_BIT_WIDTH-1:0] counts_i,
  input  logic [CELL_COUNT-1:0]                 exclude_i,
  output logic [INDEX_BIT_WIDTH-1:0]            max_index_o,
  output logic [COUNT_BIT_WIDTH-1:0]            max_count_o,
  output logic                                  any_valid_o
);

  logic [INDEX_BIT_WIDTH-1:0] best_index;
  logic [COUNT_BIT_WIDTH-1:0] best_count;
  logic                       found;

  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    best_index = '0;
    best_count = '0;
    found      = 1'b0;
    // Strict '>' keeps the earlier (lower) index on ties.
    for (int k = 0; k < CELL_COUNT; k++) begin
      if (!exclude_i[k] && (!found || counts_i[k*COUNT_BIT_WIDTH +: COUNT_BIT_WIDTH] > best_count)) begin
        best_index = INDEX_BIT_WIDTH'(k);
        best_count = counts_i[k*COUNT_BIT_WIDTH +: COUNT_BIT_WIDTH];
        found      = 1'b1;
      end
    end
  end

  assign max_index_o = best_index;
  assign max_count_o = best_count;
  assign any_valid_o = found;

endmodule

// File: rtl/binary_value_prioritizer_arbiter.sv
// Grants priority to the most confident prioritizer cell and publishes its value,
// with lock/unlock hysteresis and a one-cycle break-before-make hand-off.
module binary_value_prioritizer_arbiter
  import binary_value_prioritizer_p::*;
#(
  parameter int CELL_COUNT      = 4,
  parameter int VALUE_BIT_WIDTH = 8,
  parameter int COUNT_BIT_WIDTH = 8,
  parameter int INDEX_BIT_WIDTH = $clog2(CELL_COUNT)
) (
  input  common_p::clk_dom_s                     sys_dom_i,
  input  logic                                   clear_state_i,
  input  logic [COUNT_BIT_WIDTH-1:0]             lock_threshold_i,
  input  logic [COUNT_BIT_WIDTH-1:0]             unlock_threshold_i,
  input  logic [COUNT_BIT_WIDTH-1:0]             preempt_margin_i,
  input  logic [CELL_COUNT*VALUE_BIT_WIDTH-1:0]  cell_data_i,
  input  logic [CELL_COUNT*COUNT_BIT_WIDTH-1:0]  cell_count_i,
  input  logic [CELL_COUNT-1:0]                  cell_plateaued_i,
  output logic [CELL_COUNT-1:0]                  priority_o,
  output logic                                   value_valid_o,
  output logic [VALUE_BIT_WIDTH-1:0]             value_o,
  output logic [INDEX_BIT_WIDTH-1:0]             winner_index_o,
  output logic                                   lock_event_o
);

  function automatic logic [CELL_COUNT-1:0] onehot(input logic [INDEX_BIT_WIDTH-1:0] idx);
    return CELL_COUNT'(1) << idx;
  endfunction

  arb_state_e                  state_q, state_d;
  logic [CELL_COUNT-1:0]       priority_q, priority_d;
  logic                        valid_q, valid_d;
  logic [VALUE_BIT_WIDTH-1:0]  value_q, value_d;
  logic [INDEX_BIT_WIDTH-1:0]  winner_q, winner_d;
  logic [INDEX_BIT_WIDTH-1:0]  challenger_q, challenger_d;
  logic                        lock_event_q, lock_event_d;

  logic [CELL_COUNT-1:0]       exclude;
  logic [INDEX_BIT_WIDTH-1:0]  max_index;
  logic [COUNT_BIT_WIDTH-1:0]  max_count;
  logic                        any_valid;
  logic [COUNT_BIT_WIDTH-1:0]  winner_count, challenger_count;
  logic [COUNT_BIT_WIDTH:0]    preempt_limit;
  logic                        grant;
  logic [INDEX_BIT_WIDTH-1:0]  grant_index;

  // While locked the argmax looks only for a challenger to the current winner.
  assign exclude = (state_q == ST_LOCKED) ? onehot(winner_q) : '0;

  binary_value_argmax #(
    .CELL_COUNT      (CELL_COUNT),
    .COUNT_BIT_WIDTH (COUNT_BIT_WIDTH),
    .INDEX_BIT_WIDTH (INDEX_BIT_WIDTH)
  ) u_argmax (
    .counts_i    (cell_count_i),
    .exclude_i   (exclude),
    .max_index_o (max_index),
    .max_count_o (max_count),
    .any_valid_o (any_valid)
  );

  assign winner_count     = cell_count_i[winner_q*COUNT_BIT_WIDTH +: COUNT_BIT_WIDTH];
  assign challenger_count = cell_count_i[challenger_q*COUNT_BIT_WIDTH +: COUNT_BIT_WIDTH];
  // One extra bit so winner count plus margin cannot wrap below the challenger.
  assign preempt_limit    = {1'b0, winner_count} + {1'b0, preempt_margin_i};

  always_comb begin
    state_d      = state_q;
    priority_d   = priority_q;
    valid_d      = valid_q;
    value_d      = value_q;
    winner_d     = winner_q;
    challenger_d = challenger_q;
    lock_event_d = 1'b0;
    grant        = 1'b0;
    grant_index  = max_index;

    unique case (state_q)
      ST_SEARCH: begin
        priority_d = '0;
        valid_d    = 1'b0;
        if (any_valid && max_count >= lock_threshold_i) grant = 1'b1;
      end
      ST_LOCKED: begin
        value_d = cell_data_i[winner_q*VALUE_BIT_WIDTH +: VALUE_BIT_WIDTH];
        if (winner_count < unlock_threshold_i) begin
          state_d    = ST_SEARCH;
          priority_d = '0;
          valid_d    = 1'b0;
        end else if (!cell_plateaued_i[winner_q] && any_valid &&
                     {1'b0, max_count} > preempt_limit) begin
          state_d      = ST_HANDOFF;
          challenger_d = max_index;
          priority_d   = '0;
          valid_d      = 1'b0;
        end else begin
          priority_d = onehot(winner_q);
          valid_d    = 1'b1;
        end
      end
      ST_HANDOFF: begin
        priority_d  = '0;
        valid_d     = 1'b0;
        grant_index = challenger_q;
        if (challenger_count >= lock_threshold_i) grant = 1'b1;
        else                                      state_d = ST_SEARCH;
      end
      default: begin
        state_d    = ST_SEARCH;
        priority_d = '0;
        valid_d    = 1'b0;
      end
    endcase

    // Acquisition: value is loaded on the same edge so valid and value appear together.
    if (grant) begin
      state_d      = ST_LOCKED;
      winner_d     = grant_index;
      priority_d   = onehot(grant_index);
      valid_d      = 1'b1;
      value_d      = cell_data_i[grant_index*VALUE_BIT_WIDTH +: VALUE_BIT_WIDTH];
      lock_event_d = 1'b1;
    end
  end

  always_ff @(posedge sys_dom_i.clk) begin
    // NOTE: non-blocking assignments only in clocked logic, so every flop samples pre-edge values.
    if (sys_dom_i.sync_rst || (sys_dom_i.clk_en && clear_state_i)) begin
      state_q      <= ST_SEARCH;
      priority_q   <= '0;
      valid_q      <= 1'b0;
      value_q      <= '0;
      winner_q     <= '0;
      challenger_q <= '0;
      lock_event_q <= 1'b0;
    end else if (sys_dom_i.clk_en) begin
      state_q      <= state_d;
      priority_q   <= priority_d;
      valid_q      <= valid_d;
      value_q      <= value_d;
      winner_q     <= winner_d;
      challenger_q <= challenger_d;
      lock_event_q <= lock_event_d;
    end else begin
      // The pulse is qualified by clk_en, so it never stretches across a stall.
      lock_event_q <= 1'b0;
    end
  end

  assign priority_o     = priority_q;
  assign value_valid_o  = valid_q;
  assign value_o        = value_q;
  assign winner_index_o = winner_q;
  assign lock_event_o   = lock_event_q;

endmodule

// File: tb/tb_binary_value_prioritizer_arbiter.sv
// Directed and randomized bench for binary_value_prioritizer_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_binary_value_prioritizer_arbiter;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int CW = 8;
  localparam int IW = 2;

  localparam int MS_SEARCH  = 0;
  localparam int MS_LOCKED  = 1;
  localparam int MS_HANDOFF = 2;

  logic clk, en, rst;
  common_p::clk_dom_s sys_dom;
  assign sys_dom = {clk, en, rst};

  logic                 clear_state_i;
  logic [CW-1:0]        lock_threshold_i, unlock_threshold_i, preempt_margin_i;
  logic [N*VW-1:0]      cell_data_i;
  logic [N*CW-1:0]      cell_count_i;
  logic [N-1:0]         cell_plateaued_i;
  logic [N-1:0]         priority_o;
  logic                 value_valid_o;
  logic [VW-1:0]        value_o;
  logic [IW-1:0]        winner_index_o;
  logic                 lock_event_o;

  binary_value_prioritizer_arbiter #(
    .CELL_COUNT(N), .VALUE_BIT_WIDTH(VW), .COUNT_BIT_WIDTH(CW), .INDEX_BIT_WIDTH(IW)
  ) dut (
    .sys_dom_i          (sys_dom),
    .clear_state_i      (clear_state_i),
    .lock_threshold_i   (lock_threshold_i),
    .unlock_threshold_i (unlock_threshold_i),
    .preempt_margin_i   (preempt_margin_i),
    .cell_data_i        (cell_data_i),
    .cell_count_i       (cell_count_i),
    .cell_plateaued_i   (cell_plateaued_i),
    .priority_o         (priority_o),
    .value_valid_o      (value_valid_o),
    .value_o            (value_o),
    .winner_index_o     (winner_index_o),
    .lock_event_o       (lock_event_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus in plain integers
  int   cnt[N];
  int   dat[N];
  bit   plat[N];
  int   lock_th, unlock_th, margin;
  bit   clear;
  string phase;

  // Reference model state
  int        m_state, m_win, m_chal;
  logic [N-1:0]  m_prio;
  logic          m_valid, m_event;
  logic [VW-1:0] m_value;
  logic [N-1:0]  prev_prio;

  int tests_run, tests_failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      cell_count_i[i*CW +: CW] = CW'(cnt[i]);
      cell_data_i[i*VW +: VW]  = VW'(dat[i]);
      cell_plateaued_i[i]      = plat[i];
    end
    lock_threshold_i   = CW'(lock_th);
    unlock_threshold_i = CW'(unlock_th);
    preempt_margin_i   = CW'(margin);
    clear_state_i      = clear;
  endtask

  task automatic take(input int i);
    m_state = MS_LOCKED;
    m_win   = i;
    m_prio  = N'(1) << i;
    m_valid = 1'b1;
    m_value = VW'(dat[i]);
    m_event = 1'b1;
  endtask

  // Expected register contents after the coming edge, from the arbitration rules.
  task automatic model_update();
    int best;
    m_event = 1'b0;
    if (rst || (en && clear)) begin
      m_state = MS_SEARCH; m_prio = '0; m_valid = 1'b0; m_value = '0; m_win = 0;
    end else if (en) begin
      case (m_state)
        MS_SEARCH: begin
          best = 0;
          for (int i = 1; i < N; i++) if (cnt[i] > cnt[best]) best = i;
          if (cnt[best] >= lock_th) take(best);
        end
        MS_LOCKED: begin
          m_value = VW'(dat[m_win]);
          if (cnt[m_win] < unlock_th) begin
            m_state = MS_SEARCH; m_prio = '0; m_valid = 1'b0;
          end else if (!plat[m_win]) begin
            best = -1;
            for (int i = 0; i < N; i++)
              if (i != m_win && (best < 0 || cnt[i] > cnt[best])) best = i;
            if (cnt[best] > cnt[m_win] + margin) begin
              m_state = MS_HANDOFF; m_chal = best; m_prio = '0; m_valid = 1'b0;
            end
          end
        end
        default: begin
          if (cnt[m_chal] >= lock_th) take(m_chal);
          else m_state = MS_SEARCH;
        end
      endcase
    end
  endtask

  task automatic step();
    drive();
    model_update();
    prev_prio = priority_o;
    @(posedge clk);
    #1;
    check("priority",   32'(priority_o),     32'(m_prio));
    check("valid",      32'(value_valid_o),  32'(m_valid));
    check("value",      32'(value_o),        32'(m_value));
    check("winner",     32'(winner_index_o), 32'(m_win));
    check("lock_event", 32'(lock_event_o),   32'(m_event));
    check("at_most_one_grant", 32'($countones(priority_o) <= 1), 32'd1);
    check("break_before_make",
          32'((prev_prio == '0) || (priority_o == '0) || (priority_o == prev_prio)), 32'd1);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    m_state = MS_SEARCH; m_win = 0; m_chal = 0;
    m_prio = '0; m_valid = 1'b0; m_value = '0; m_event = 1'b0;
    cnt = '{0, 0, 0, 0}; dat = '{0, 0, 0, 0}; plat = '{0, 0, 0, 0};
    lock_th = 8; unlock_th = 4; margin = 5; clear = 1'b0;
    en = 1'b1; rst = 1'b1;
    drive();

    phase = "reset";
    step();
    rst = 1'b0;

    phase = "idle_search";
    repeat (20) step();

    phase = "acquire";
    cnt = '{3, 10, 10, 2}; dat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    step(); step();

    phase = "release";
    cnt = '{3, 10, 5, 2};
    step();
    cnt[1] = 3;
    step();
    cnt[1] = 10;
    step(); step();

    phase = "preempt";
    cnt[3] = 16;
    step(); step(); step();

    phase = "relock_cell1";
    cnt[3] = 2;
    step(); step();

    phase = "margin_boundary";
    cnt[3] = 15;
    repeat (3) step();

    phase = "plateau_blocks";
    plat[1] = 1'b1; cnt[3] = 16;
    repeat (3) step();

    phase = "handoff_to_search";
    plat[1] = 1'b0;
    step();
    cnt[3] = 2;
    step(); step();

    phase = "no_wrap";
    cnt[1] = 200; margin = 100; cnt[3] = 255;
    repeat (3) step();
    margin = 5; cnt[1] = 10; cnt[3] = 2;
    step();

    phase = "clear_and_enable";
    en = 1'b0; clear = 1'b1;
    repeat (2) step();
    en = 1'b1;
    step();
    clear = 1'b0;
    step();
    en = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    step(); step();

    phase = "hysteresis";
    lock_th = 8; unlock_th = 12; cnt = '{0, 10, 0, 0};
    repeat (6) step();

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        lock_th   = int'($urandom_range(4, 16));
        unlock_th = int'($urandom_range(0, 16));
        margin    = int'($urandom_range(0, 6));
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) cnt[i] = int'($urandom_range(0, 20));
        if ($urandom_range(0, 3) == 0) plat[i] = 1'($urandom_range(0, 1));
        dat[i] = int'($urandom_range(0, 255));
      end
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
